// File: rtl/cpu_pkg.sv
// Shared opcodes, FSM states and instruction field positions for the CPU1 sequencer.
package cpu_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_MOV = 4'h6;
    localparam logic [3:0] OP_SHL = 4'h7;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_JZ  = 4'h9;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam int OP_MSB   = 15;
    localparam int OP_LSB   = 12;
    localparam int RD_MSB   = 11;
    localparam int RD_LSB   = 9;
    localparam int RS1_MSB  = 8;
    localparam int RS1_LSB  = 6;
    localparam int RS2_MSB  = 5;
    localparam int RS2_LSB  = 3;
    localparam int IMM_MSB  = 7;
    localparam int IMM_LSB  = 0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_READ   = 3'd3,
        ST_EXEC   = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decode: class flags, ALU opcode and operand fields.
module ctrl_decode
    import cpu_pkg::*;
(
    input  logic [15:0] ir,
    output logic        is_alu,
    output logic        is_jmp,
    output logic        is_jz,
    output logic        is_hlt,
    output logic [3:0]  alu_op,
    output logic [2:0]  rd,
    output logic [2:0]  rs1,
    output logic [2:0]  rs2,
    output logic [7:0]  imm8
);

    logic [3:0] op;

    assign op   = ir[OP_MSB:OP_LSB];
    assign rd   = ir[RD_MSB:RD_LSB];
    assign rs1  = ir[RS1_MSB:RS1_LSB];
    assign rs2  = ir[RS2_MSB:RS2_LSB];
    assign imm8 = ir[IMM_MSB:IMM_LSB];

    always_comb begin
        is_alu = 1'b0;
        is_jmp = 1'b0;
        is_jz  = 1'b0;
        is_hlt = 1'b0;
        alu_op = OP_NOP;
        unique case (1'b1)
            (op >= OP_ADD && op <= OP_SHL): begin
                is_alu = 1'b1;
                alu_op = op;
            end
            (op == OP_JMP): is_jmp = 1'b1;
            (op == OP_JZ):  is_jz  = 1'b1;
            (op == OP_HLT): is_hlt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_ctrl.sv
// Multi-cycle fetch/decode/read/exec sequencer driving the CPU1 register file.
// Optional retired-instruction counter enabled by CPU_CTRL_INSTRET_EN.
module cpu_ctrl
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        res,
    output logic        imem_req,
    output logic [7:0]  imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_data,
    input  logic        zf,
    output logic [2:0]  LSEL,
    output logic [2:0]  RSEL,
    output logic [2:0]  OSEL,
    output logic        LOUT,
    output logic        ROUT,
    output logic        OIN,
    output logic [3:0]  alu_op,
`ifdef CPU_CTRL_INSTRET_EN
    output logic [15:0] instret,
`endif
    output logic        halted
);

    state_t      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [15:0] ir_q, ir_d;

    logic        is_alu, is_jmp, is_jz, is_hlt;
    logic [3:0]  dec_op;
    logic [2:0]  rd, rs1, rs2;
    logic [7:0]  imm8;

    ctrl_decode u_dec (
        .ir     (ir_q),
        .is_alu (is_alu),
        .is_jmp (is_jmp),
        .is_jz  (is_jz),
        .is_hlt (is_hlt),
        .alu_op (dec_op),
        .rd     (rd),
        .rs1    (rs1),
        .rs2    (rs2),
        .imm8   (imm8)
    );

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q <= ST_IDLE;
            pc_q    <= 8'h00;
            ir_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        imem_req  = 1'b0;
        imem_addr = 8'h00;
        LSEL      = 3'd0;
        RSEL      = 3'd0;
        OSEL      = 3'd0;
        LOUT      = 1'b0;
        ROUT      = 1'b0;
        OIN       = 1'b0;
        alu_op    = OP_NOP;
        halted    = 1'b0;
        unique case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                imem_req  = 1'b1;
                imem_addr = pc_q;
                if (imem_ack) begin
                    ir_d    = imem_data;
                    pc_d    = pc_q + 8'd1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_d = ST_FETCH;
                if (is_alu)
                    state_d = ST_READ;
                else if (is_hlt)
                    state_d = ST_HALT;
                else if (is_jmp || (is_jz && zf))
                    pc_d = imm8;
            end
            ST_READ: begin
                LSEL    = rs1;
                RSEL    = rs2;
                LOUT    = 1'b1;
                ROUT    = 1'b1;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                LSEL    = rs1;
                RSEL    = rs2;
                OSEL    = rd;
                LOUT    = 1'b1;
                ROUT    = 1'b1;
                OIN     = 1'b1;
                alu_op  = dec_op;
                state_d = ST_FETCH;
            end
            ST_HALT: halted = 1'b1;
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef CPU_CTRL_INSTRET_EN
    logic retire;

    // HLT never retires; ALU ops retire on leaving EXEC instead of DECODE
    assign retire = (state_q == ST_EXEC)
                 || (state_q == ST_DECODE && !is_alu && !is_hlt);

    always_ff @(posedge clk or negedge res) begin
        if (!res)
            instret <= 16'h0000;
        else if (retire)
            instret <= instret + 16'd1;
    end
`endif

endmodule
